player_shot_controller: RTL and testbench
=========================================

# player_shot_controller

Owns the player's single laser shot: launches it from the player ship on a fire press, steps it up the screen once per movement tick, and drives `shot_pixel` for the current scan position. It sits directly upstream of the invader formation controller, which consumes `shot_pixel`. It also consumes that controller's `ship_pixel_out` to detect a hit, retire the shot and count kills.

## Interface
Parameters:
- `SHOT_W`, 2: shot width in pixels
- `SHOT_H`, 12: shot height in pixels
- `SHOT_STEP`, 4: pixels moved up per `move_tick`
- `LAUNCH_Y`, 440: top row of the shot at launch
- `TOP_Y`, 32: top playfield row; the shot retires when it would cross this row
- `H_ACTIVE`, 640: visible width
- `COOL_TICKS`, 8: `move_tick`s of lockout after a hit or miss

Ports:
- `clk`  in  1  system pixel clock; the only clock
- `rst`  in  1  synchronous, active-high reset; top level drives `~on_sw`
- `move_tick`  in  1  single-cycle movement enable (frame rate)
- `fire`  in  1  debounced fire button, level
- `player_x`  in  11  left edge of the player ship
- `player_w`  in  6  player ship width
- `pixel_x`, `pixel_y`  in  11  current scan coordinates
- `ship_pixel`  in  1  invader pixel present at (`pixel_x`, `pixel_y`)
- `shot_pixel`  out  1  shot pixel present at (`pixel_x`, `pixel_y`)
- `shot_active`  out  1  high in state FLY
- `hit`  out  1  single-cycle pulse, one cycle after a collision
- `kills`  out  5  invaders destroyed, saturates at 24

## Operation
State machine: IDLE, FLY, COOL.

Launch:
- IDLE and a rising edge of `fire` (`fire` high, `fire_q` low): go to FLY.
- Latch `shot_y = LAUNCH_Y`.
- Latch `shot_x = player_x + player_w/2 - SHOT_W/2`, clamped to `[0, H_ACTIVE-SHOT_W]`. Compute at 12 bits, then clamp.

Flight:
- FLY and `move_tick`: if `shot_y < TOP_Y + SHOT_STEP`, this is a miss; go to COOL and clear the cooldown counter. Otherwise `shot_y -= SHOT_STEP`.
- Unsigned arithmetic; the compare precedes the subtract, so there is no wrap.

Collision:
- FLY and `shot_pixel && ship_pixel` in the same cycle: go to COOL, pulse `hit` on the next cycle, and increment `kills` unless it is already 24.

Cooldown:
- Count `move_tick`s. When the count reaches `COOL_TICKS`, go to IDLE.

Shot pixel: `shot_pixel = (state==FLY) && shot_x <= pixel_x < shot_x+SHOT_W && shot_y <= pixel_y < shot_y+SHOT_H`. It is combinational from registered state and the pixel inputs.

Boundary rules:
- Collision and `move_tick` in the same cycle: collision wins, no position update.
- Collision on the same cycle as the miss condition: counts as a hit.
- `fire` edges in FLY or COOL are ignored, not queued. A held `fire` does not relaunch; a new rising edge is required.
- `player_x` changes during flight do not move the shot.
- `rst` mid-flight: returns to IDLE at the next edge, the shot vanishes and `kills` clears.

## Timing
Reset values:
- state IDLE
- `shot_x`, `shot_y`, `kills`, cooldown counter: 0
- `fire_q`: 1, so a button held through reset does not fire
- Outputs: `shot_pixel` 0, `shot_active` 0, `hit` 0

Latencies:
- Fire rising edge sampled at edge N: `shot_active` high after N, and the shot is drawable from cycle N+1.
- `shot_pixel`: zero latency relative to the pixel inputs. The invader controller sees the overlap in the same cycle it occurs, so the shot stays drawn in the collision cycle.
- `hit`: high for exactly the cycle after the collision. `shot_pixel` is 0 from that cycle on.
- `kills`: updates on the same edge that raises `hit`.

## Structure
- Shared package `inv_pkg`: `H_ACTIVE`, `V_ACTIVE`, `TOP_Y`, `INV_COUNT` (24), and the state encoding `shot_state_t` (IDLE/FLY/COOL).
- Sub-module `rise_detect`: one-flop rising-edge detector with reset value 1, used for `fire`.
- Everything else is inline, roughly 150–200 lines.

## Test plan
- Reset release with `fire` held high: no launch. Release, then press: FLY next cycle, `shot_y`=440, `shot_x`=`player_x`+`player_w`/2−1.
- 102 `move_tick`s with no invaders: `shot_y` goes 440→32. On the next tick: COOL, `shot_pixel` 0, `hit` stays 0. After 8 further ticks: IDLE.
- `ship_pixel` forced high when `pixel_x`=`shot_x`, `pixel_y`=`shot_y` (at `shot_y`=200): `shot_pixel`=1 that cycle, `hit`=1 next cycle only, `kills` 0→1, state COOL.
- Collision coincident with `move_tick`: `shot_y` unchanged, `hit` asserted once.
- `player_x`=636, `player_w`=16: `shot_x` clamps to 638. Fire pressed 5 times during FLY: no relaunch.
- 25 forced hits: `kills` saturates at 24. `rst` during FLY: IDLE next edge, `kills`=0.

Source files
------------

// File: rtl/inv_pkg.sv
// Items shared between the invader-game blocks: playfield geometry, formation
// size and the player shot state encoding.
package inv_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int V_ACTIVE  = 480;
    localparam int TOP_Y     = 32;
    localparam int INV_COUNT = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FLY  = 2'd1,
        COOL = 2'd2
    } shot_state_t;

    // Centre the shot on the ship; a ship hugging either edge pins the shot to the playfield.
    function automatic logic [10:0] shot_launch_x(
        input logic [10:0] px,
        input logic [5:0]  pw,
        input logic [11:0] half_shot,
        input logic [11:0] max_x
    );
        logic [11:0] w_centre;
        logic [11:0] w_left;
        logic [10:0] w_res;
        w_centre = {1'b0, px} + ({6'd0, pw} >> 1);
        w_left   = w_centre - half_shot;
        if (w_centre < half_shot) begin
            w_res = 11'd0;
        end else if (w_left > max_x) begin
            w_res = max_x[10:0];
        end else begin
            w_res = w_left[10:0];
        end
        return w_res;
    endfunction

endpackage

// File: rtl/player_shot_controller_rise_detect.sv
// One-flop rising-edge detector. The flop resets high so a level already
// asserted when reset releases does not register as an edge.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_rise
);

    logic r_q;

    // Previous-cycle copy of the input.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 1'b1;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_rise = i_d & ~r_q;

endmodule

// File: rtl/player_shot_controller.sv
// Player laser shot: launches on a fire edge, climbs once per move_tick, retires
// on an invader hit or at the top row, then locks out relaunch for a cooldown.
module player_shot_controller
    import inv_pkg::*;
#(
    parameter int SHOT_W     = 2,
    parameter int SHOT_H     = 12,
    parameter int SHOT_STEP  = 4,
    parameter int LAUNCH_Y   = 440,
    parameter int TOP_Y      = inv_pkg::TOP_Y,
    parameter int H_ACTIVE   = inv_pkg::H_ACTIVE,
    parameter int COOL_TICKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_tick,
    input  logic        fire,
    input  logic [10:0] player_x,
    input  logic [5:0]  player_w,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        ship_pixel,
    output logic        shot_pixel,
    output logic        shot_active,
    output logic        hit,
    output logic [4:0]  kills
);

    localparam int COOL_W = $clog2(COOL_TICKS + 1);

    shot_state_t       r_state;
    shot_state_t       w_state_next;
    logic [10:0]       r_shot_x;
    logic [10:0]       r_shot_y;
    logic [COOL_W-1:0] r_cool;
    logic [4:0]        r_kills;
    logic              r_hit;

    logic w_fire_rise;
    logic w_collide;
    logic w_at_top;
    logic w_cool_done;
    logic w_in_x;
    logic w_in_y;

    rise_detect u_fire_edge (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_d    (fire),
        .o_rise (w_fire_rise)
    );

    // Compare before subtracting so the shot never wraps below row 0.
    assign w_at_top    = ({1'b0, r_shot_y} < 12'(TOP_Y + SHOT_STEP));
    assign w_cool_done = (r_cool == COOL_W'(COOL_TICKS - 1));
    assign w_in_x      = ({1'b0, pixel_x} >= {1'b0, r_shot_x}) &&
                         ({1'b0, pixel_x} <  ({1'b0, r_shot_x} + 12'(SHOT_W)));
    assign w_in_y      = ({1'b0, pixel_y} >= {1'b0, r_shot_y}) &&
                         ({1'b0, pixel_y} <  ({1'b0, r_shot_y} + 12'(SHOT_H)));
    assign w_collide   = shot_pixel && ship_pixel;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a collision outranks the movement step in the same cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_fire_rise) w_state_next = FLY;
                else             w_state_next = IDLE;
            end
            FLY: begin
                if (w_collide)                  w_state_next = COOL;
                else if (move_tick && w_at_top) w_state_next = COOL;
                else                            w_state_next = FLY;
            end
            COOL: begin
                if (move_tick && w_cool_done) w_state_next = IDLE;
                else                          w_state_next = COOL;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Output decode; the shot stays drawn in the collision cycle itself.
    always_comb begin
        shot_active = 1'b0;
        shot_pixel  = 1'b0;
        if (r_state == FLY) begin
            shot_active = 1'b1;
            shot_pixel  = w_in_x && w_in_y;
        end else begin
            shot_active = 1'b0;
            shot_pixel  = 1'b0;
        end
    end

    // Shot position, cooldown count, kill tally and hit pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shot_x <= 11'd0;
            r_shot_y <= 11'd0;
            r_cool   <= '0;
            r_kills  <= 5'd0;
            r_hit    <= 1'b0;
        end else begin
            r_hit <= w_collide;
            case (r_state)
                IDLE: begin
                    if (w_fire_rise) begin
                        r_shot_y <= 11'(LAUNCH_Y);
                        r_shot_x <= shot_launch_x(player_x, player_w,
                                                  12'(SHOT_W / 2), 12'(H_ACTIVE - SHOT_W));
                    end
                end
                FLY: begin
                    if (w_collide) begin
                        r_cool <= '0;
                        if (r_kills != 5'(INV_COUNT)) begin
                            r_kills <= r_kills + 5'd1;
                        end
                    end else if (move_tick) begin
                        if (w_at_top) begin
                            r_cool <= '0;
                        end else begin
                            r_shot_y <= r_shot_y - 11'(SHOT_STEP);
                        end
                    end
                end
                COOL: begin
                    if (move_tick && !w_cool_done) begin
                        r_cool <= r_cool + COOL_W'(1);
                    end
                end
                default: r_cool <= '0;
            endcase
        end
    end

    assign hit   = r_hit;
    assign kills = r_kills;

endmodule

// File: tb/tb_player_shot_controller.sv
// Self-checking bench for player_shot_controller: directed boundary scenarios
// followed by a randomized run, all compared against a behavioural shot model.
module tb_player_shot_controller;

    localparam int SHOT_W = 2, SHOT_H = 12, SHOT_STEP = 4, LAUNCH_Y = 440;
    localparam int TOP_Y = 32, H_ACTIVE = 640, COOL_TICKS = 8, MAX_KILLS = 24;
    localparam int MD_IDLE = 0, MD_FLY = 1, MD_COOL = 2;

    typedef struct packed {
        int mode;
        int x;
        int y;
        int kills;
        int cooled;
        bit hit;
        bit fire_q;
    } model_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        move_tick = 1'b0;
    logic        fire = 1'b1;
    logic [10:0] player_x = 11'd100;
    logic [5:0]  player_w = 6'd20;
    logic [10:0] pixel_x = 11'd0;
    logic [10:0] pixel_y = 11'd0;
    logic        ship_pixel = 1'b0;
    logic        shot_pixel;
    logic        shot_active;
    logic        hit;
    logic [4:0]  kills;

    model_t m;
    bit     cmp_en = 1'b0;
    int     n_checks = 0;
    int     n_err = 0;

    player_shot_controller dut (
        .clk         (clk),
        .rst         (rst),
        .move_tick   (move_tick),
        .fire        (fire),
        .player_x    (player_x),
        .player_w    (player_w),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .ship_pixel  (ship_pixel),
        .shot_pixel  (shot_pixel),
        .shot_active (shot_active),
        .hit         (hit),
        .kills       (kills)
    );

    always #5 clk = ~clk;

    function automatic bit m_pix(model_t c, int px, int py);
        return (c.mode == MD_FLY) && (px >= c.x) && (px < c.x + SHOT_W) &&
               (py >= c.y) && (py < c.y + SHOT_H);
    endfunction

    // What the shot looks like after one clock, from the game rules.
    function automatic model_t model_next(model_t c, bit r, bit mt, bit f, int px, int pw,
                                          int sx, int sy, bit sp);
        model_t n = c;
        bit rise = f && !c.fire_q;
        n.fire_q = f;
        n.hit = 1'b0;
        if (r) begin
            n = '0;
            n.mode = MD_IDLE;
            n.fire_q = 1'b1;
        end else if (c.mode == MD_IDLE) begin
            if (rise) begin
                n.mode = MD_FLY;
                n.y = LAUNCH_Y;
                n.x = px + pw / 2 - SHOT_W / 2;
                if (n.x < 0) n.x = 0;
                if (n.x > H_ACTIVE - SHOT_W) n.x = H_ACTIVE - SHOT_W;
            end
        end else if (c.mode == MD_FLY) begin
            if (m_pix(c, sx, sy) && sp) begin
                n.hit = 1'b1;
                n.mode = MD_COOL;
                n.cooled = 0;
                if (c.kills < MAX_KILLS) n.kills = c.kills + 1;
            end else if (mt) begin
                if (c.y - SHOT_STEP < TOP_Y) begin
                    n.mode = MD_COOL;
                    n.cooled = 0;
                end else begin
                    n.y = c.y - SHOT_STEP;
                end
            end
        end else begin
            if (mt) begin
                n.cooled = c.cooled + 1;
                if (n.cooled >= COOL_TICKS) n.mode = MD_IDLE;
            end
        end
        return n;
    endfunction

    always @(posedge clk)
        m <= model_next(m, rst, move_tick, fire, int'(player_x), int'(player_w),
                        int'(pixel_x), int'(pixel_y), ship_pixel);

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("shot_pixel", int'(shot_pixel), int'(m_pix(m, int'(pixel_x), int'(pixel_y))));
            chk("shot_active", int'(shot_active), int'(m.mode == MD_FLY));
            chk("hit", int'(hit), int'(m.hit));
            chk("kills", int'(kills), m.kills);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        move_tick = 1'b1;
        cyc(1);
        move_tick = 1'b0;
        cyc(1);
    endtask

    task automatic press();
        fire = 1'b0;
        cyc(1);
        fire = 1'b1;
        cyc(1);
    endtask

    task automatic probe(input int px, input int py, input int exp, input string name);
        ship_pixel = 1'b0;
        pixel_x = 11'(px);
        pixel_y = 11'(py);
        #1;
        chk(name, int'(shot_pixel), exp);
    endtask

    task automatic collide_at(input int px, input int py, input bit with_tick);
        pixel_x = 11'(px);
        pixel_y = 11'(py);
        ship_pixel = 1'b1;
        move_tick = with_tick;
        #1;
        chk("coll_cycle_pixel", int'(shot_pixel), 1);
        cyc(1);
        ship_pixel = 1'b0;
        move_tick = 1'b0;
        chk("coll_hit", int'(hit), 1);
        chk("coll_inactive", int'(shot_active), 0);
    endtask

    initial begin
        int div;
        cyc(3);
        cmp_en = 1'b1;
        // Button held through reset release must not launch.
        rst = 1'b0;
        cyc(5);
        chk("held_no_launch", int'(shot_active), 0);
        chk("reset_kills", int'(kills), 0);

        press();
        chk("launch_active", int'(shot_active), 1);
        probe(109, 440, 1, "launch_tl");
        probe(110, 451, 1, "launch_br");
        probe(108, 440, 0, "launch_left");
        probe(111, 440, 0, "launch_right");
        probe(109, 439, 0, "launch_above");
        probe(109, 452, 0, "launch_below");
        player_x = 11'd300;
        cyc(1);
        probe(109, 440, 1, "player_move_ignored");

        // Full climb to the top row, then a miss and the cooldown.
        repeat (102) tick();
        probe(109, 32, 1, "top_row");
        probe(109, 31, 0, "top_row_above");
        tick();
        chk("miss_inactive", int'(shot_active), 0);
        probe(109, 32, 0, "miss_gone");
        chk("miss_no_hit", int'(hit), 0);
        player_x = 11'd100;
        repeat (7) tick();
        press();
        chk("cool_blocks_fire", int'(shot_active), 0);
        tick();
        press();
        chk("idle_after_cool", int'(shot_active), 1);

        // Hit at row 200.
        repeat (60) tick();
        probe(109, 200, 1, "row200");
        collide_at(109, 200, 1'b0);
        chk("kills_one", int'(kills), 1);
        probe(109, 200, 0, "post_hit_pixel");
        cyc(1);
        chk("hit_single", int'(hit), 0);

        // Collision coincident with move_tick.
        repeat (8) tick();
        press();
        collide_at(109, 440, 1'b1);
        chk("kills_two", int'(kills), 2);

        // Right-edge clamp and ignored presses during flight.
        repeat (8) tick();
        player_x = 11'd636;
        player_w = 6'd16;
        press();
        probe(638, 440, 1, "clamp_x");
        probe(637, 440, 0, "clamp_left");
        probe(639, 451, 1, "clamp_br");
        repeat (5) press();
        player_x = 11'd0;
        cyc(1);
        probe(638, 440, 1, "no_relaunch");
        repeat (102) tick();
        collide_at(638, 32, 1'b1);
        chk("miss_row_hit_kills", int'(kills), 3);

        // Saturation.
        for (int k = 0; k < 25; k++) begin
            repeat (8) tick();
            press();
            collide_at(m.x, m.y, 1'b0);
        end
        chk("kills_saturate", int'(kills), MAX_KILLS);

        // Reset mid-flight.
        repeat (8) tick();
        press();
        tick();
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_inactive", int'(shot_active), 0);
        chk("rst_kills", int'(kills), 0);
        probe(7, 436, 0, "rst_gone");

        // Randomized run.
        for (int i = 0; i < 6000; i++) begin
            div = (i < 3000) ? 40 : 3;
            move_tick = ($urandom_range(3) == 0);
            if ($urandom_range(5) == 0) fire = ~fire;
            if ($urandom_range(30) == 0) begin
                player_x = 11'($urandom_range(700));
                player_w = 6'($urandom_range(63));
            end
            if ($urandom_range(200) == 0) player_x = 11'($urandom_range(2047));
            if (m.mode == MD_FLY && $urandom_range(1) == 0) begin
                pixel_x = 11'(m.x - 1 + int'($urandom_range(3)));
                pixel_y = 11'(m.y - 1 + int'($urandom_range(13)));
            end else begin
                pixel_x = 11'($urandom_range(700));
                pixel_y = 11'($urandom_range(500));
            end
            ship_pixel = ($urandom_range(div) == 0);
            rst = ($urandom_range(600) == 0);
            cyc(1);
        end
        rst = 1'b0;
        ship_pixel = 1'b0;
        move_tick = 1'b0;
        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
